// File: rtl/arp_pkg.sv
// Shared widths, table entry layout and controller states for the ARP cache.
package arp_pkg;

    localparam int IP_W  = 32;
    localparam int MAC_W = 48;
    localparam int AGE_W = 16;

    typedef struct packed {
        logic             valid;
        logic [IP_W-1:0]  ip;
        logic [MAC_W-1:0] mac;
        logic [AGE_W-1:0] age;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        STORE,
        FLUSH
    } state_e;

endpackage

// File: rtl/arp_age_tick.sv
// Free-running prescaler: one-cycle tick every AGE_TICK cycles; no backpressure.
// Only instantiated when ARP_AGING_EN is defined.
module arp_age_tick #(
    parameter int unsigned AGE_TICK = 125_000_000
) (
    input  logic sys_clk,
    input  logic reset_n,
    output logic tick
);

    localparam int unsigned CW = $clog2(AGE_TICK + 1);
    localparam logic [CW-1:0] LAST = CW'(AGE_TICK - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        tick_d = (cnt_q == LAST);
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/arp_table.sv
// IP->MAC cache, sequential scan: lookup hit at index k answers k+1 cycles after accept, miss after DEPTH, store DEPTH+1.
// Ready only in IDLE (flush > store > lookup); ARP_AGING_EN adds per-entry expiry.
module arp_table
    import arp_pkg::*;
#(
    parameter int unsigned      DEPTH    = 8,
    parameter logic [IP_W-1:0]  DE_IP0   = 32'hC0A8_007B,
    parameter logic [MAC_W-1:0] DE_MAC0  = 48'h1234_5678_9abc,
    parameter int unsigned      AGE_TICK = 125_000_000,
    parameter int unsigned      AGE_MAX  = 300
) (
    input  logic                       sys_clk,
    input  logic                       reset_n,
    input  logic                       lookup_valid,
    output logic                       lookup_ready,
    input  logic [IP_W-1:0]            lookup_ip,
    output logic                       resp_valid,
    output logic                       resp_hit,
    output logic [MAC_W-1:0]           resp_mac,
    input  logic                       store_valid,
    output logic                       store_ready,
    input  logic [IP_W-1:0]            store_ip,
    input  logic [MAC_W-1:0]           store_mac,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned IDX_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] WR_IDX   = IDX_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam entry_t DEF_ENTRY = '{valid: 1'b1, ip: DE_IP0, mac: DE_MAC0, age: '0};

    if (DEPTH < 2 || DEPTH > 64 || AGE_TICK == 0 || AGE_MAX == 0) begin : g_bad_param
        $error("arp_table: illegal parameter set");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IP_W-1:0]    ip_q, ip_d;
    logic [MAC_W-1:0]   mac_q, mac_d;
    logic               match_vld_q, match_vld_d;
    logic [PTR_W-1:0]   match_idx_q, match_idx_d;
    logic               free_vld_q, free_vld_d;
    logic [PTR_W-1:0]   free_idx_q, free_idx_d;
    logic [PTR_W-1:0]   victim_q, victim_d;
    logic               resp_valid_q, resp_valid_d;
    logic               resp_hit_q, resp_hit_d;
    logic [MAC_W-1:0]   resp_mac_q, resp_mac_d;
    logic [CNT_W-1:0]   count_q, count_d;
    entry_t             tbl_q [DEPTH];
    entry_t             tbl_d [DEPTH];
    logic [PTR_W-1:0]   scan_ptr;
    logic [PTR_W-1:0]   wr_idx;

`ifdef ARP_AGING_EN
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(AGE_MAX - 1);
    logic age_tick;

    arp_age_tick #(
        .AGE_TICK (AGE_TICK)
    ) u_age_tick (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .tick    (age_tick)
    );
`endif

    assign scan_ptr = idx_q[PTR_W-1:0];

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ip_d         = ip_q;
        mac_d        = mac_q;
        match_vld_d  = match_vld_q;
        match_idx_d  = match_idx_q;
        free_vld_d   = free_vld_q;
        free_idx_d   = free_idx_q;
        victim_d     = victim_q;
        resp_valid_d = 1'b0;
        resp_hit_d   = 1'b0;
        resp_mac_d   = '0;
        wr_idx       = '0;
        tbl_d        = tbl_q;

`ifdef ARP_AGING_EN
        // Ageing goes first so a store write or flush to the same entry overrides it.
        if (age_tick) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (tbl_q[i].valid) begin
                    if (tbl_q[i].age >= AGE_LAST) tbl_d[i].valid = 1'b0;
                    else                          tbl_d[i].age   = tbl_q[i].age + 1'b1;
                end
            end
        end
`endif

        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = FLUSH;
                end else if (store_valid) begin
                    // A zero IP is consumed without touching the table.
                    if (store_ip != '0) begin
                        state_d     = STORE;
                        idx_d       = '0;
                        ip_d        = store_ip;
                        mac_d       = store_mac;
                        match_vld_d = 1'b0;
                        free_vld_d  = 1'b0;
                    end
                end else if (lookup_valid) begin
                    state_d = LOOKUP;
                    idx_d   = '0;
                    ip_d    = lookup_ip;
                end
            end
            LOOKUP: begin
                if (tbl_q[scan_ptr].valid && tbl_q[scan_ptr].ip == ip_q) begin
                    resp_valid_d = 1'b1;
                    resp_hit_d   = 1'b1;
                    resp_mac_d   = tbl_q[scan_ptr].mac;
                    state_d      = IDLE;
                end else if (idx_q == LAST_IDX) begin
                    resp_valid_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            STORE: begin
                if (idx_q == WR_IDX) begin
                    if (match_vld_q) begin
                        wr_idx = match_idx_q;
                    end else if (free_vld_q) begin
                        wr_idx = free_idx_q;
                    end else begin
                        wr_idx   = victim_q;
                        victim_d = (victim_q == LAST_PTR) ? '0 : victim_q + 1'b1;
                    end
                    tbl_d[wr_idx] = '{valid: 1'b1, ip: ip_q, mac: mac_q, age: '0};
                    state_d       = IDLE;
                end else begin
                    if (tbl_q[scan_ptr].valid && tbl_q[scan_ptr].ip == ip_q && !match_vld_q) begin
                        match_vld_d = 1'b1;
                        match_idx_d = scan_ptr;
                    end
                    if (!tbl_q[scan_ptr].valid && !free_vld_q) begin
                        free_vld_d = 1'b1;
                        free_idx_d = scan_ptr;
                    end
                    idx_d = idx_q + 1'b1;
                end
            end
            FLUSH: begin
                for (int i = 0; i < DEPTH; i++) tbl_d[i] = '0;
                tbl_d[0] = DEF_ENTRY;
                victim_d = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) count_d = count_d + CNT_W'(tbl_q[i].valid);
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            ip_q         <= '0;
            mac_q        <= '0;
            match_vld_q  <= 1'b0;
            match_idx_q  <= '0;
            free_vld_q   <= 1'b0;
            free_idx_q   <= '0;
            victim_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_mac_q   <= '0;
            count_q      <= CNT_W'(1);
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= (i == 0) ? DEF_ENTRY : '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ip_q         <= ip_d;
            mac_q        <= mac_d;
            match_vld_q  <= match_vld_d;
            match_idx_q  <= match_idx_d;
            free_vld_q   <= free_vld_d;
            free_idx_q   <= free_idx_d;
            victim_q     <= victim_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_mac_q   <= resp_mac_d;
            count_q      <= count_d;
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= tbl_d[i];
        end
    end

    // Ready mirrors the IDLE priority so a handshake never claims an op that loses arbitration.
    assign store_ready  = (state_q == IDLE) && !flush;
    assign lookup_ready = (state_q == IDLE) && !flush && !store_valid;
    assign resp_valid   = resp_valid_q;
    assign resp_hit     = resp_hit_q;
    assign resp_mac     = resp_mac_q;
    assign count        = count_q;

endmodule

// File: tb/tb_arp_table.sv
// Directed bench for arp_table; the ageing sequence replaces the main one when ARP_AGING_EN is defined.
module tb_arp_table;

`ifdef ARP_AGING_EN
    localparam int unsigned TB_AGE_TICK = 4;
    localparam int unsigned TB_AGE_MAX  = 3;
`else
    localparam int unsigned TB_AGE_TICK = 125_000_000;
    localparam int unsigned TB_AGE_MAX  = 300;
`endif
    localparam logic [31:0] DEF_IP  = 32'hC0A8_007B;
    localparam logic [47:0] DEF_MAC = 48'h1234_5678_9abc;
    localparam logic [31:0] IP_A    = 32'h0A00_0005;
    localparam logic [47:0] MAC_A   = 48'hA0A0_0000_0005;
    localparam logic [47:0] MAC_B   = 48'hB0B0_0000_0005;
    localparam logic [47:0] MAC_C   = 48'hC0C0_0000_0201;
    localparam logic [47:0] MAC_D   = 48'hD0D0_0000_0202;
    localparam logic [31:0] IP_X    = 32'h0A00_0303;
    localparam logic [47:0] MAC_X   = 48'hE0E0_0000_0303;

    logic        sys_clk;
    logic        reset_n;
    logic        lookup_valid;
    logic        lookup_ready;
    logic [31:0] lookup_ip;
    logic        resp_valid;
    logic        resp_hit;
    logic [47:0] resp_mac;
    logic        store_valid;
    logic        store_ready;
    logic [31:0] store_ip;
    logic [47:0] store_mac;
    logic        flush;
    logic [3:0]  count;

    int n_chk  = 0;
    int n_pass = 0;

    arp_table #(
        .DEPTH    (8),
        .DE_IP0   (DEF_IP),
        .DE_MAC0  (DEF_MAC),
        .AGE_TICK (TB_AGE_TICK),
        .AGE_MAX  (TB_AGE_MAX)
    ) dut (
        .sys_clk      (sys_clk),
        .reset_n      (reset_n),
        .lookup_valid (lookup_valid),
        .lookup_ready (lookup_ready),
        .lookup_ip    (lookup_ip),
        .resp_valid   (resp_valid),
        .resp_hit     (resp_hit),
        .resp_mac     (resp_mac),
        .store_valid  (store_valid),
        .store_ready  (store_ready),
        .store_ip     (store_ip),
        .store_mac    (store_mac),
        .flush        (flush),
        .count        (count)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(lookup_ready && store_ready) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) chk("idle_timeout", 1, 0);
    endtask

    // exp_lat < 0 skips the latency comparison.
    task automatic do_lookup(input string tag, input logic [31:0] ip, input logic exp_hit,
                             input logic [47:0] exp_mac, input int exp_lat);
        int lat = 0;
        wait_idle();
        lookup_valid = 1'b1;
        lookup_ip    = ip;
        step();
        lookup_valid = 1'b0;
        lookup_ip    = 32'hDEAD_BEEF;
        do begin
            step();
            lat++;
        end while (!resp_valid && lat < 200);
        if (lat >= 200) chk($sformatf("%s_timeout", tag), 1, 0);
        if (exp_lat >= 0) chk($sformatf("%s_lat", tag), lat, exp_lat);
        chk($sformatf("%s_hit", tag), resp_hit, exp_hit);
        chk($sformatf("%s_mac", tag), resp_mac, exp_mac);
        step();
        chk($sformatf("%s_strobe", tag), resp_valid, 0);
    endtask

    // Returns one cycle after the controller is idle again, so count reflects the write.
    task automatic do_store(input string tag, input logic [31:0] ip, input logic [47:0] mac,
                            input int exp_lat);
        int lat = 0;
        wait_idle();
        store_valid = 1'b1;
        store_ip    = ip;
        store_mac   = mac;
        step();
        store_valid = 1'b0;
        store_ip    = 32'h5555_5555;
        store_mac   = 48'h5555_5555_5555;
        do begin
            step();
            lat++;
        end while (!store_ready && lat < 200);
        if (lat >= 200) chk($sformatf("%s_timeout", tag), 1, 0);
        if (exp_lat >= 0) chk($sformatf("%s_lat", tag), lat, exp_lat);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset_n      = 1'b0;
        lookup_valid = 1'b0;
        lookup_ip    = '0;
        store_valid  = 1'b0;
        store_ip     = '0;
        store_mac    = '0;
        flush        = 1'b0;
        repeat (3) step();
        chk("rst_count", count, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_hit", resp_hit, 0);
        chk("rst_resp_mac", resp_mac, 0);
        reset_n = 1'b1;
        step();
        chk("rst_lookup_ready", lookup_ready, 1);

`ifdef ARP_AGING_EN
        do_store("age_st", IP_A, MAC_A, 9);
        do_lookup("age_fresh", IP_A, 1'b1, MAC_A, -1);
        repeat (4) step();
        do_store("age_restore", IP_A, MAC_B, 9);
        do_lookup("age_kept", IP_A, 1'b1, MAC_B, -1);
        repeat (16) step();
        do_lookup("age_expired", IP_A, 1'b0, 48'h0, 8);
        chk("age_count", count, 0);
`else
        do_lookup("def", DEF_IP, 1'b1, DEF_MAC, 1);

        do_store("st_a", IP_A, MAC_A, 9);
        chk("cnt_a", count, 2);
        do_lookup("a", IP_A, 1'b1, MAC_A, 2);
        do_lookup("miss9", 32'h0A00_0009, 1'b0, 48'h0, 8);

        do_store("st_upd", IP_A, MAC_B, 9);
        chk("cnt_upd", count, 2);
        do_lookup("a_upd", IP_A, 1'b1, MAC_B, 2);

        do_store("st_zero", 32'h0, MAC_A, 1);
        chk("cnt_zero", count, 2);
        do_lookup("zero", 32'h0, 1'b0, 48'h0, 8);

        for (int i = 1; i <= 6; i++)
            do_store("st_fill", 32'h0A00_0100 + 32'(i), {16'hF000, 32'(i)}, 9);
        chk("cnt_full", count, 8);
        do_lookup("fill6", 32'h0A00_0106, 1'b1, {16'hF000, 32'd6}, 8);

        do_store("st_v0", 32'h0A00_0201, MAC_C, 9);
        chk("cnt_v0", count, 8);
        do_lookup("v0", 32'h0A00_0201, 1'b1, MAC_C, 1);
        do_lookup("def_gone", DEF_IP, 1'b0, 48'h0, 8);

        do_store("st_v1", 32'h0A00_0202, MAC_D, 9);
        chk("cnt_v1", count, 8);
        do_lookup("v1", 32'h0A00_0202, 1'b1, MAC_D, 2);
        do_lookup("a_gone", IP_A, 1'b0, 48'h0, 8);
        do_lookup("fill1", 32'h0A00_0101, 1'b1, {16'hF000, 32'd1}, 3);

        // Flush, store and lookup all presented together.
        wait_idle();
        flush        = 1'b1;
        store_valid  = 1'b1;
        store_ip     = IP_X;
        store_mac    = MAC_X;
        lookup_valid = 1'b1;
        lookup_ip    = 32'h0A00_0201;
        step();
        flush        = 1'b0;
        lookup_valid = 1'b0;
        chk("fl_busy", store_ready, 0);
        step();
        chk("fl_one_cycle", store_ready, 1);
        chk("fl_no_lookup", resp_valid, 0);
        step();
        chk("fl_count", count, 1);
        chk("fl_store_taken", store_ready, 0);
        store_valid = 1'b0;
        store_ip    = 32'h5555_5555;
        n = 0;
        while (!store_ready && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) chk("fl_timeout", 1, 0);
        step();
        chk("fl_count_x", count, 2);
        do_lookup("x", IP_X, 1'b1, MAC_X, 2);
        do_lookup("def_back", DEF_IP, 1'b1, DEF_MAC, 1);
        do_lookup("v0_flushed", 32'h0A00_0201, 1'b0, 48'h0, 8);

        // Reset in the middle of a store scan.
        wait_idle();
        store_valid = 1'b1;
        store_ip    = 32'h0A00_0404;
        store_mac   = 48'hF0F0_0000_0404;
        step();
        store_valid = 1'b0;
        repeat (3) step();
        reset_n = 1'b0;
        #1;
        chk("abort_count", count, 1);
        chk("abort_resp", resp_valid, 0);
        chk("abort_ready", store_ready, 1);
        step();
        reset_n = 1'b1;
        step();
        do_lookup("abort_y", 32'h0A00_0404, 1'b0, 48'h0, 8);
        do_lookup("abort_x", IP_X, 1'b0, 48'h0, 8);
        do_lookup("abort_def", DEF_IP, 1'b1, DEF_MAC, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/arp_table.md
ARP_TABLE -- requirements
Module: arp_table

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of entries (legal 2..64).
REQ-002 SHALL have parameter DE_IP0, default 192.168.0.123, IP loaded into entry 0 at reset.
REQ-003 SHALL have parameter DE_MAC0, default 48'h123456789abc, MAC loaded into entry 0 at reset.
REQ-004 SHALL have parameter AGE_TICK, default 125_000_000, clock cycles per age tick.
REQ-005 SHALL have parameter AGE_MAX, default 300, age ticks before an entry expires.
REQ-006 SHALL have one clock and an asynchronous active-low reset: sys_clk and reset_n.
REQ-007 SHALL have the following ports:
- sys_clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- lookup_valid  in  1  lookup request.
- lookup_ready  out  1  lookup accepted.
- lookup_ip  in  32  lookup IP.
- resp_valid  out  1  one-cycle response strobe.
- resp_hit  out  1  lookup found the IP.
- resp_mac  out  48  MAC on hit, 0 on miss.
- store_valid  in  1  store request.
- store_ready  out  1  store accepted.
- store_ip  in  32  IP to store.
- store_mac  in  48  MAC to store.
- flush  in  1  clear the table.
- count  out  clog2(DEPTH+1)  number of valid entries.

Function
REQ-008 SHALL use FSM states IDLE, LOOKUP, STORE, FLUSH; lookup_ready and store_ready are high only in IDLE.
REQ-009 SHALL apply this priority in IDLE: flush, then store_valid, then lookup_valid.
REQ-010 SHALL latch lookup_ip and store_ip/store_mac at acceptance; later input changes have no effect on the operation in flight.
REQ-011 Lookup SHALL scan indices 0..DEPTH-1, one per cycle, comparing only valid entries.
REQ-012 Lookup hit at index k:
- resp_valid=1, resp_hit=1, resp_mac=entry MAC exactly k+1 cycles after acceptance;
- return to IDLE.
REQ-013 Lookup miss SHALL give resp_valid=1, resp_hit=0, resp_mac=0 DEPTH cycles after acceptance; resp_valid lasts one cycle.
REQ-014 Store SHALL scan all DEPTH entries (DEPTH cycles), recording the first IP match and the first invalid index.
- Write target, in order: the matching entry (MAC update), else the first invalid entry, else the entry at the round-robin victim pointer.
- The write happens in the cycle after the scan; total latency DEPTH+1.
REQ-015 The victim pointer SHALL reset to 0 and increment modulo DEPTH after each victim replacement only.
REQ-016 store_ip==0 SHALL be accepted and discarded with no table change; duplicates never occupy two entries.
REQ-017 Flush SHALL take one cycle: all entries invalidated, entry 0 reloaded with DE_IP0/DE_MAC0, victim pointer reset to 0.
REQ-018 count SHALL reflect the number of valid entries, registered, updated the cycle after any change.

Reset
REQ-019 Asynchronous reset SHALL force:
- FSM to IDLE;
- resp_valid, resp_hit, resp_mac to 0;
- count to 1;
- entry 0 valid with the defaults, all other entries invalid;
- age state cleared.
REQ-020 Reset mid-scan SHALL abort the operation with no response and no partial write.

Configuration
REQ-021 With ARP_AGING_EN defined:
- a prescaler SHALL emit an age tick every AGE_TICK cycles;
- each valid entry SHALL increment its age on each tick;
- an entry reaching AGE_MAX SHALL be invalidated;
- a store write SHALL reset the written entry's age to 0;
- expiry during a scan takes effect immediately for indices not yet compared.
REQ-022 Without ARP_AGING_EN, no age logic SHALL exist and entries persist until overwritten, flushed or reset.

Structure
REQ-023 Package arp_pkg SHALL hold the IP/MAC width constants, the entry typedef (valid, ip, mac, age) and the FSM state enum.
REQ-024 The prescaler SHALL be the sub-module arp_age_tick, instantiated only under ARP_AGING_EN.

Verification
REQ-025 Reset then lookup 192.168.0.123 -> resp_hit=1, resp_mac=48'h123456789abc, 1 cycle after acceptance.
REQ-026 Store 10.0.0.5/MAC A, then lookup 10.0.0.5 -> hit at index 1 after 2 cycles; lookup 10.0.0.9 -> miss after DEPTH cycles, resp_mac=0.
REQ-027 Fill all 8 entries, then store a 9th IP -> entry 0 replaced; a 10th IP -> entry 1 replaced; count stays 8.
REQ-028 Store an existing IP with a new MAC -> same index updated, count unchanged; store_ip=0 -> no change.
REQ-029 Flush with store_valid and lookup_valid asserted in the same cycle -> flush wins, count=1, store accepted the next cycle.
REQ-030 ARP_AGING_EN, AGE_TICK=4, AGE_MAX=3 -> stored entry misses after 12 idle cycles; a re-store at cycle 10 keeps it alive.
